// File: rtl/gmii_tx_arbiter_pkg.sv
// Shared types and constants for the two-source GMII transmit arbiter.
// State encoding, GMII idle values and default timing limits live here.
package gmii_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_GRANT_WAIT = 2'd1,
    ST_SEND       = 2'd2,
    ST_IPG        = 2'd3
  } arb_state_e;

  localparam logic [7:0] GMII_IDLE_TXD   = 8'h00;
  localparam logic       GMII_IDLE_TX_EN = 1'b0;
  localparam logic       GMII_IDLE_TX_ER = 1'b0;

  localparam int DEF_IPG_CYCLES    = 12;
  localparam int DEF_GRANT_TIMEOUT = 16;
  localparam int DEF_MAX_FRAME_LEN = 1530;
  localparam int LEN_W             = 11;

  function automatic logic [1:0] grant_vec(input logic k);
    return k ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/gmii_tx_arbiter_if.sv
// Bundle of link status, request/grant and GMII signals around the arbiter.
// Handshake: req[k] is a level held until gnt[k] rises; gnt[k] falling marks end of frame.
interface gmii_tx_arbiter_if;
  logic       code_sync_status;
  logic       transmitting;
  logic [1:0] req;
  logic [1:0] gnt;
  logic [7:0] TXD_0;
  logic       TX_EN_0;
  logic       TX_ER_0;
  logic [7:0] TXD_1;
  logic       TX_EN_1;
  logic       TX_ER_1;
  logic [7:0] TXD;
  logic       TX_EN;
  logic       TX_ER;
  logic       frame_abort;

  modport slave (
    input  code_sync_status, transmitting, req,
    input  TXD_0, TX_EN_0, TX_ER_0, TXD_1, TX_EN_1, TX_ER_1,
    output gnt, TXD, TX_EN, TX_ER, frame_abort
  );

  modport master (
    output code_sync_status, transmitting, req,
    output TXD_0, TX_EN_0, TX_ER_0, TXD_1, TX_EN_1, TX_ER_1,
    input  gnt, TXD, TX_EN, TX_ER, frame_abort
  );
endinterface

// File: rtl/gmii_tx_arbiter_tx_mux.sv
// Registered 2:1 GMII mux; force_err_i wins over force_idle_i and emits
// the error-propagation pattern (TX_EN=1, TX_ER=1, TXD=0).
module gmii_tx_mux
  import gmii_tx_arbiter_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sel_i,
  input  logic       force_idle_i,
  input  logic       force_err_i,
  input  logic [7:0] txd0_i,
  input  logic       tx_en0_i,
  input  logic       tx_er0_i,
  input  logic [7:0] txd1_i,
  input  logic       tx_en1_i,
  input  logic       tx_er1_i,
  output logic [7:0] txd_o,
  output logic       tx_en_o,
  output logic       tx_er_o
);

  logic [7:0] txd_q, txd_d;
  logic       tx_en_q, tx_en_d;
  logic       tx_er_q, tx_er_d;

  always_comb begin
    txd_d   = GMII_IDLE_TXD;
    tx_en_d = GMII_IDLE_TX_EN;
    tx_er_d = GMII_IDLE_TX_ER;
    if (force_err_i) begin
      txd_d   = 8'h00;
      tx_en_d = 1'b1;
      tx_er_d = 1'b1;
    end else if (!force_idle_i) begin
      txd_d   = sel_i ? txd1_i   : txd0_i;
      tx_en_d = sel_i ? tx_en1_i : tx_en0_i;
      tx_er_d = sel_i ? tx_er1_i : tx_er0_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      txd_q   <= GMII_IDLE_TXD;
      tx_en_q <= GMII_IDLE_TX_EN;
      tx_er_q <= GMII_IDLE_TX_ER;
    end else begin
      txd_q   <= txd_d;
      tx_en_q <= tx_en_d;
      tx_er_q <= tx_er_d;
    end
  end

  assign txd_o   = txd_q;
  assign tx_en_o = tx_en_q;
  assign tx_er_o = tx_er_q;

endmodule

// File: rtl/gmii_tx_arbiter.sv
// Round-robin arbiter sharing one PCS TRANSMIT path between two GMII sources,
// with grant timeout, inter-packet gap, frame-length cap and abort on link loss.
module gmii_tx_arbiter
  import gmii_tx_arbiter_pkg::*;
#(
  parameter int IPG_CYCLES    = DEF_IPG_CYCLES,
  parameter int GRANT_TIMEOUT = DEF_GRANT_TIMEOUT,
  parameter int MAX_FRAME_LEN = DEF_MAX_FRAME_LEN
) (
  input  logic                Clk,
  input  logic                mr_main_reset,
  gmii_tx_arbiter_if.slave    bus,
  output arb_state_e          state_o
);

  localparam int WAIT_W = $clog2(GRANT_TIMEOUT + 1);
  localparam int IPG_W  = $clog2(IPG_CYCLES + 1);

  arb_state_e         state_q, state_d;
  logic [1:0]         gnt_q, gnt_d;
  logic               last_q, last_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [IPG_W-1:0]   ipg_q, ipg_d;
  logic               abort_q, abort_d;

  logic               force_idle, force_err;
  logic               en_k;
  logic               pick_k;
  logic [LEN_W-1:0]   len_now;

  // The current (or most recently) granted requester owns the mux.
  assign en_k    = last_q ? bus.TX_EN_1 : bus.TX_EN_0;
  // Length including the cycle being sampled now.
  assign len_now = len_q + LEN_W'(1);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    wait_d     = wait_q;
    len_d      = len_q;
    ipg_d      = ipg_q;
    abort_d    = 1'b0;
    force_idle = 1'b1;
    force_err  = 1'b0;
    pick_k     = (bus.req == 2'b11) ? ~last_q : bus.req[1];
    unique case (state_q)
      ST_IDLE: begin
        gnt_d = 2'b00;
        if (bus.code_sync_status && !bus.transmitting && |bus.req) begin
          gnt_d   = grant_vec(pick_k);
          last_d  = pick_k;
          wait_d  = '0;
          state_d = ST_GRANT_WAIT;
        end
      end
      ST_GRANT_WAIT: begin
        wait_d = wait_q + WAIT_W'(1);
        if (en_k) begin
          force_idle = 1'b0;
          len_d      = LEN_W'(1);
          state_d    = ST_SEND;
        end else if (!bus.code_sync_status) begin
          gnt_d   = 2'b00;
          state_d = ST_IDLE;
        end else if (wait_q == WAIT_W'(GRANT_TIMEOUT - 1)) begin
          gnt_d   = 2'b00;
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (!bus.code_sync_status || (en_k && len_now == LEN_W'(MAX_FRAME_LEN))) begin
          force_err = 1'b1;
          abort_d   = 1'b1;
          gnt_d     = 2'b00;
          ipg_d     = '0;
          state_d   = ST_IPG;
        end else if (!en_k) begin
          gnt_d   = 2'b00;
          ipg_d   = '0;
          state_d = ST_IPG;
        end else begin
          force_idle = 1'b0;
          len_d      = len_now;
        end
      end
      ST_IPG: begin
        if (ipg_q == IPG_W'(IPG_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          ipg_d = ipg_q + IPG_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (mr_main_reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= 2'b00;
      last_q  <= 1'b1;
      wait_q  <= '0;
      len_q   <= '0;
      ipg_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wait_q  <= wait_d;
      len_q   <= len_d;
      ipg_q   <= ipg_d;
      abort_q <= abort_d;
    end
  end

  logic [7:0] mux_txd;
  logic       mux_tx_en;
  logic       mux_tx_er;

  gmii_tx_mux u_mux (
    .clk_i        (Clk),
    .rst_i        (mr_main_reset),
    .sel_i        (last_q),
    .force_idle_i (force_idle),
    .force_err_i  (force_err),
    .txd0_i       (bus.TXD_0),
    .tx_en0_i     (bus.TX_EN_0),
    .tx_er0_i     (bus.TX_ER_0),
    .txd1_i       (bus.TXD_1),
    .tx_en1_i     (bus.TX_EN_1),
    .tx_er1_i     (bus.TX_ER_1),
    .txd_o        (mux_txd),
    .tx_en_o      (mux_tx_en),
    .tx_er_o      (mux_tx_er)
  );

  assign bus.gnt         = gnt_q;
  assign bus.TXD         = mux_txd;
  assign bus.TX_EN       = mux_tx_en;
  assign bus.TX_ER       = mux_tx_er;
  assign bus.frame_abort = abort_q;
  assign state_o         = state_q;

endmodule

// File: tb/tb_gmii_tx_arbiter.sv
// Directed bench for gmii_tx_arbiter: grant latency, IPG spacing, round robin,
// link-loss abort, grant timeout, length cap and mid-frame reset.
module tb_gmii_tx_arbiter;
  import gmii_tx_arbiter_pkg::*;

  logic       Clk;
  logic       mr_main_reset;
  arb_state_e state_o;
  int         n_vec;
  int         n_err;

  gmii_tx_arbiter_if bus();

  gmii_tx_arbiter dut (
    .Clk           (Clk),
    .mr_main_reset (mr_main_reset),
    .bus           (bus),
    .state_o       (state_o)
  );

  // Clock and reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_vec++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic drive_src(input logic k, input logic en, input logic er, input logic [7:0] d);
    if (k) begin
      bus.TX_EN_1 = en; bus.TX_ER_1 = er; bus.TXD_1 = d;
    end else begin
      bus.TX_EN_0 = en; bus.TX_ER_0 = er; bus.TXD_0 = d;
    end
  endtask

  // Drives len data cycles from requester k starting in the first GRANT_WAIT cycle,
  // checking the 1-cycle-delayed copy on the GMII output, then ends the frame.
  task automatic send_frame(input logic k, input int len, input logic [7:0] base, input string tag);
    int bad;
    logic [7:0] d;
    bad = 0;
    for (int i = 0; i < len; i++) begin
      d = base + 8'(i);
      drive_src(k, 1'b1, 1'b0, d);
      tick();
      if (bus.TX_EN !== 1'b1 || bus.TX_ER !== 1'b0 || bus.TXD !== d) bad++;
    end
    drive_src(k, 1'b0, 1'b0, 8'h00);
    tick();
    check({tag, "_data"}, 32'(bad), 32'd0);
    check({tag, "_end_en"}, 32'(bus.TX_EN), 32'd0);
    check({tag, "_end_gnt"}, 32'(bus.gnt), 32'd0);
  endtask

  // Waits for any grant; n is the number of ticks taken (0 on timeout gives gnt=0).
  task automatic wait_grant(output logic [1:0] g, output int n, output logic idle_ok);
    n = 0;
    idle_ok = 1'b1;
    g = 2'b00;
    while (n < 40) begin
      tick();
      n++;
      if (bus.TX_EN !== 1'b0) idle_ok = 1'b0;
      if (bus.gnt !== 2'b00) begin
        g = bus.gnt;
        break;
      end
    end
  endtask

  // Scoreboard of expected round-robin grants
  logic [1:0] exp_q[$];

  initial begin
    logic [1:0] g;
    int         n;
    logic       idle_ok;
    int         held;
    int         cnt;
    logic [1:0] e;

    n_vec = 0;
    n_err = 0;
    mr_main_reset = 1'b1;
    bus.code_sync_status = 1'b0;
    bus.transmitting = 1'b0;
    bus.req = 2'b00;
    drive_src(1'b0, 1'b0, 1'b0, 8'h00);
    drive_src(1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    tick();
    mr_main_reset = 1'b0;

    check("rst_gnt",   32'(bus.gnt), 32'd0);
    check("rst_txd",   32'(bus.TXD), 32'd0);
    check("rst_tx_en", 32'(bus.TX_EN), 32'd0);
    check("rst_tx_er", 32'(bus.TX_ER), 32'd0);
    check("rst_abort", 32'(bus.frame_abort), 32'd0);
    check("rst_state", 32'(state_o), 32'(ST_IDLE));

    // First grant one cycle after req with link up; preamble + SFD frame.
    bus.code_sync_status = 1'b1;
    bus.req = 2'b01;
    tick();
    check("t1_gnt", 32'(bus.gnt), 32'h1);
    bus.req = 2'b00;
    for (int i = 0; i < 9; i++) begin
      e[0] = 1'b0;
      drive_src(1'b0, 1'b1, 1'b0, (i < 8) ? 8'h55 : 8'hD5);
      tick();
      check("t1_txd", 32'(bus.TXD), (i < 8) ? 32'h55 : 32'hD5);
    end
    drive_src(1'b0, 1'b0, 1'b0, 8'h00);
    bus.req = 2'b01;
    tick();
    check("t1_end_en", 32'(bus.TX_EN), 32'd0);
    check("t1_end_state", 32'(state_o), 32'(ST_IPG));
    wait_grant(g, n, idle_ok);
    check("t1_ipg_gnt", 32'(g), 32'h1);
    check("t1_ipg_len", 32'(n), 32'd13);
    check("t1_ipg_idle", 32'(idle_ok), 32'd1);

    // Both requesting: grants alternate, each preceded by the full gap.
    bus.req = 2'b11;
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    send_frame(1'b0, 64, 8'h10, "rr0");
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      wait_grant(g, n, idle_ok);
      check("rr_gnt", 32'(g), 32'(e));
      check("rr_gap", 32'(n), 32'd13);
      check("rr_idle", 32'(idle_ok), 32'd1);
      if (exp_q.size() == 0) bus.req = 2'b00;
      send_frame(e[1], 64, 8'h40, "rr");
    end
    repeat (14) tick();
    check("rr_done_state", 32'(state_o), 32'(ST_IDLE));
    check("rr_done_gnt", 32'(bus.gnt), 32'd0);

    // No grant while the link is down; grant the cycle after it comes up.
    bus.code_sync_status = 1'b0;
    bus.req = 2'b01;
    repeat (5) tick();
    check("t3_nosync_gnt", 32'(bus.gnt), 32'd0);
    bus.code_sync_status = 1'b1;
    tick();
    check("t3_sync_gnt", 32'(bus.gnt), 32'h1);
    bus.req = 2'b00;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      drive_src(1'b0, 1'b1, 1'b0, 8'hA0 + 8'(i));
      tick();
      if (bus.TX_EN !== 1'b1 || bus.TXD !== 8'hA0 + 8'(i)) cnt++;
    end
    check("t3_data", 32'(cnt), 32'd0);
    bus.code_sync_status = 1'b0;
    tick();
    check("t3_abort_en",  32'(bus.TX_EN), 32'd1);
    check("t3_abort_er",  32'(bus.TX_ER), 32'd1);
    check("t3_abort_txd", 32'(bus.TXD), 32'd0);
    check("t3_abort_pls", 32'(bus.frame_abort), 32'd1);
    check("t3_abort_gnt", 32'(bus.gnt), 32'd0);
    drive_src(1'b0, 1'b0, 1'b0, 8'h00);
    idle_ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.TX_EN !== 1'b0 || bus.frame_abort !== 1'b0) idle_ok = 1'b0;
    end
    check("t3_ipg_idle", 32'(idle_ok), 32'd1);
    check("t3_ipg_state", 32'(state_o), 32'(ST_IDLE));
    bus.code_sync_status = 1'b1;

    // Requester 1 never starts; grant revoked after 16 cycles, requester 0 next.
    bus.req = 2'b10;
    tick();
    check("t4_gnt1", 32'(bus.gnt), 32'h2);
    bus.req = 2'b11;
    drive_src(1'b0, 1'b1, 1'b0, 8'hFF);
    held = 1;
    idle_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.TX_EN !== 1'b0) idle_ok = 1'b0;
      if (bus.gnt === 2'b10) held++;
      else break;
    end
    drive_src(1'b0, 1'b0, 1'b0, 8'h00);
    check("t4_held", 32'(held), 32'd16);
    check("t4_drop_gnt", 32'(bus.gnt), 32'd0);
    check("t4_ignore_en", 32'(idle_ok), 32'd1);
    tick();
    check("t4_next_gnt", 32'(bus.gnt), 32'h1);
    bus.req = 2'b00;

    // Oversize frame is cut with an error cycle as TX_EN cycle 1530.
    cnt = 0;
    for (int i = 0; i < 2100; i++) begin
      drive_src(1'b0, 1'b1, 1'b0, 8'(i + 1));
      tick();
      if (bus.TX_EN === 1'b1) cnt++;
      if (bus.TX_ER === 1'b1) break;
    end
    check("t5_len", 32'(cnt), 32'd1530);
    check("t5_abort_pls", 32'(bus.frame_abort), 32'd1);
    check("t5_abort_txd", 32'(bus.TXD), 32'd0);
    check("t5_abort_gnt", 32'(bus.gnt), 32'd0);
    tick();
    check("t5_post_en", 32'(bus.TX_EN), 32'd0);
    check("t5_post_pls", 32'(bus.frame_abort), 32'd0);
    idle_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.TX_EN !== 1'b0) idle_ok = 1'b0;
    end
    check("t5_hold_idle", 32'(idle_ok), 32'd1);
    drive_src(1'b0, 1'b0, 1'b0, 8'h00);

    // Reset mid-frame, then hold off grants while TRANSMIT is busy.
    bus.req = 2'b01;
    wait_grant(g, n, idle_ok);
    check("t6_gnt", 32'(g), 32'h1);
    bus.req = 2'b00;
    for (int i = 0; i < 5; i++) begin
      drive_src(1'b0, 1'b1, 1'b0, 8'h33);
      tick();
    end
    check("t6_sending", 32'(bus.TX_EN), 32'd1);
    mr_main_reset = 1'b1;
    bus.transmitting = 1'b1;
    bus.req = 2'b10;
    tick();
    mr_main_reset = 1'b0;
    drive_src(1'b0, 1'b0, 1'b0, 8'h00);
    check("t6_rst_en",    32'(bus.TX_EN), 32'd0);
    check("t6_rst_er",    32'(bus.TX_ER), 32'd0);
    check("t6_rst_txd",   32'(bus.TXD), 32'd0);
    check("t6_rst_pls",   32'(bus.frame_abort), 32'd0);
    check("t6_rst_gnt",   32'(bus.gnt), 32'd0);
    check("t6_rst_state", 32'(state_o), 32'(ST_IDLE));
    repeat (5) tick();
    check("t6_busy_gnt", 32'(bus.gnt), 32'd0);
    bus.transmitting = 1'b0;
    tick();
    check("t6_free_gnt", 32'(bus.gnt), 32'h2);

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
